pkt_rr_sched: RTL and testbench
===============================

Name: pkt_rr_sched

Overview:
- Round-robin scheduler that shares one packet queue between N_FLOW requesting flows.
- Arbitrates per-flow enqueue requests into a shared internal FIFO of DEPTH entries and tags each entry with its flow id.
- Caps per-flow occupancy at FLOW_CAP so that no single flow can monopolise the buffer.
- Presents the queue head on a valid/deque interface for the downstream packet consumer.

Parameters:
- N_FLOW, 4, number of requesting flows (>=2).
- DATA_W, 32, packet descriptor width in bits.
- DEPTH, 16, shared FIFO entries (>=2; need not be a power of two).
- FLOW_CAP, 8, maximum entries one flow may hold (1..DEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N_FLOW  per-flow enqueue request.
- in_data  input  N_FLOW*DATA_W  per-flow descriptor; flow i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  N_FLOW  one-hot (or zero) grant; an enqueue occurs when in_valid[i] & in_ready[i].
- out_valid  output  1  FIFO not empty.
- out_data  output  DATA_W  head descriptor.
- out_flow  output  max(1,$clog2(N_FLOW))  flow id of the head entry.
- out_deque_en  input  1  consumer pops the head when out_valid is also high.
- occ  output  $clog2(DEPTH+1)  total entries held.
- flow_full  output  N_FLOW  flow_full[i] = (flow_cnt[i] == FLOW_CAP).

Behaviour:
- Reset (asynchronous, rst=1):
  - count, wr_ptr, rd_ptr, rr_ptr and all flow_cnt go to 0.
  - out_valid=0, occ=0, flow_full=0.
  - in_ready is forced to 0 while rst is high.
  - Contents present at a mid-operation reset are discarded; memory contents are don't-care.
- Eligibility: flow i is eligible iff in_valid[i] & (flow_cnt[i] < FLOW_CAP) & (count < DEPTH).
  - Full is evaluated on the current count only; a pop in the same cycle does not free space for a push in that cycle.
- Arbitration (combinational):
  - Search from rr_ptr upward, wrapping at N_FLOW.
  - The first eligible flow gets in_ready[i]=1; all other in_ready bits are 0.
  - in_ready may depend on in_valid.
  - If no flow is eligible, in_ready=0.
- RR update: on a grant to flow g, rr_ptr <= (g+1) mod N_FLOW; with no grant, rr_ptr is held.
- Push:
  - mem[wr_ptr] <= {g, in_data[g]}.
  - wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
  - flow_cnt[g] += 1.
- Pop (out_valid & out_deque_en):
  - rd_ptr advances with the same wrap rule.
  - flow_cnt[out_flow] -= 1.
  - out_deque_en while out_valid=0 is ignored.
- Head read: first-word fall-through.
  - out_data/out_flow are taken combinationally from mem[rd_ptr].
  - out_valid = (count != 0).
- Latency: a push in cycle T is visible at the head no earlier than cycle T+1; there is no same-cycle bypass.
- Simultaneous push and pop:
  - count is unchanged.
  - Granted flow +1, popped flow -1; if they are the same flow, its count is unchanged.
- Invariants:
  - count = sum of flow_cnt.
  - count <= DEPTH.
  - Each flow_cnt <= FLOW_CAP.
  - FIFO order is preserved across all flows.
- occ = count (registered). flow_full is derived combinationally from the registered flow_cnt.

Test Plan:
- Reset, then all in_valid=4'b1111 held, no deque, FLOW_CAP=8, DEPTH=16.
  - Grants go to flows 0,1,2,3,0,1,... for 16 cycles.
  - occ reaches 16, after which in_ready=0.
  - Each flow_cnt=4.
- Only flow 2 valid, no deque, FLOW_CAP=8.
  - 8 pushes, then flow_full[2]=1 and in_ready[2]=0 while occ=8.
  - Asserting in_valid[0] then gets an immediate grant.
- Push flow 1 data 0xA5A5_0001 at cycle T.
  - out_valid=0 at T, and out_valid=1 with out_data=0xA5A5_0001, out_flow=1 at T+1.
  - With out_deque_en=1 at T+1, occ returns to 0 at T+2.
- Steady state, occ=5, flow 3 pushes while its own entry is popped in the same cycle.
  - occ stays 5 and flow_cnt[3] is unchanged.
  - FIFO pointers wrap past DEPTH-1 correctly across 40 such cycles, with data order matching the push order.
- FIFO full (occ=16), out_deque_en=1 with requests pending.
  - No grant in that cycle; a grant follows the next cycle (occ 15->16).
- Assert rst asynchronously mid-stream with occ=9.
  - out_valid, occ, flow_full and in_ready drop to 0 without a clock edge.
  - After release, the first grant goes to the lowest-index valid flow (rr_ptr=0).

Source files
------------

// File: rtl/pkt_rr_sched.sv
// Round-robin scheduler sharing one DEPTH-entry FIFO among N_FLOW flows, with a per-flow occupancy cap.
// Head is first-word fall-through, pushes visible one cycle later; grants withheld when full or flow at cap.
module pkt_rr_sched #(
    parameter int N_FLOW   = 4,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int FLOW_CAP = 8,
    parameter int FW       = (N_FLOW > 1) ? $clog2(N_FLOW) : 1,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_FLOW-1:0]          in_valid,
    input  logic [N_FLOW*DATA_W-1:0]   in_data,
    output logic [N_FLOW-1:0]          in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [FW-1:0]              out_flow,
    input  logic                       out_deque_en,
    output logic [CW-1:0]              occ,
    output logic [N_FLOW-1:0]          flow_full
);
    localparam int PW  = $clog2(DEPTH);
    localparam int FCW = $clog2(FLOW_CAP + 1);

    logic [DATA_W-1:0] r_mem_dat  [DEPTH];
    logic [FW-1:0]     r_mem_flow [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [FW-1:0]     r_rr_ptr;
    logic [FCW-1:0]    r_flow_cnt [N_FLOW];

    logic [N_FLOW-1:0] w_elig;
    logic              w_found;
    logic [FW-1:0]     w_gnt_id;
    logic              w_push;
    logic              w_pop;
    logic [FW-1:0]     w_head_flow;

    // Full is judged on the registered count only: a same-cycle pop never frees room.
    always_comb begin
        for (int i = 0; i < N_FLOW; i++) begin
            w_elig[i] = in_valid[i] && !rst
                        && (r_flow_cnt[i] < FCW'(FLOW_CAP))
                        && (r_count < CW'(DEPTH));
        end
    end

    always_comb begin : p_arb
        logic [FW:0] idx;
        w_found  = 1'b0;
        w_gnt_id = '0;
        in_ready = '0;
        idx      = '0;
        for (int k = 0; k < N_FLOW; k++) begin
            idx = {1'b0, r_rr_ptr} + (FW+1)'(k);
            if (idx >= (FW+1)'(N_FLOW)) begin
                idx = idx - (FW+1)'(N_FLOW);
            end
            if (!w_found && w_elig[idx[FW-1:0]]) begin
                w_found                 = 1'b1;
                w_gnt_id                = idx[FW-1:0];
                in_ready[idx[FW-1:0]]   = 1'b1;
            end
        end
    end

    assign w_push      = w_found;
    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid && out_deque_en;
    assign w_head_flow = r_mem_flow[r_rd_ptr];
    assign out_flow    = w_head_flow;
    assign out_data    = r_mem_dat[r_rd_ptr];
    assign occ         = r_count;

    always_comb begin
        for (int i = 0; i < N_FLOW; i++) begin
            flow_full[i] = (r_flow_cnt[i] == FCW'(FLOW_CAP));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dat[r_wr_ptr]  <= in_data[DATA_W*int'(w_gnt_id) +: DATA_W];
            r_mem_flow[r_wr_ptr] <= w_gnt_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
            for (int i = 0; i < N_FLOW; i++) begin
                r_flow_cnt[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
                r_rr_ptr <= (w_gnt_id == FW'(N_FLOW-1)) ? '0 : w_gnt_id + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            for (int i = 0; i < N_FLOW; i++) begin
                if ((w_push && w_gnt_id == FW'(i)) && !(w_pop && w_head_flow == FW'(i))) begin
                    r_flow_cnt[i] <= r_flow_cnt[i] + 1'b1;
                end else if (!(w_push && w_gnt_id == FW'(i)) && (w_pop && w_head_flow == FW'(i))) begin
                    r_flow_cnt[i] <= r_flow_cnt[i] - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pkt_rr_sched.sv
// Directed bench for pkt_rr_sched: reference model plus expected-head queue checked on every pop.
module tb_pkt_rr_sched;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int D  = 16;
    localparam int CAP = 8;
    localparam int FW = 2;
    localparam int CW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_valid;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [FW-1:0]     out_flow;
    logic              out_deque_en;
    logic [CW-1:0]     occ;
    logic [N-1:0]      flow_full;

    pkt_rr_sched #(.N_FLOW(N), .DATA_W(DW), .DEPTH(D), .FLOW_CAP(CAP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_flow(out_flow),
        .out_deque_en(out_deque_en), .occ(occ), .flow_full(flow_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [FW+DW-1:0] sb[$];
    logic [DW-1:0]    dat [N];
    int               m_cnt;
    int               m_fc [N];
    int               m_rr;
    int               seq = 0;
    int               last_g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt = 0;
        m_rr  = 0;
        for (int f = 0; f < N; f++) m_fc[f] = 0;
    endtask

    // One cycle: drive at the falling edge, check settled outputs, advance model, wait next falling edge.
    task automatic step(input logic [N-1:0] v, input logic dq);
        logic [N-1:0]     exp_rdy;
        logic [N-1:0]     exp_full;
        logic [FW+DW-1:0] head;
        int               g;
        int               idx;
        in_valid     = v;
        out_deque_en = dq;
        for (int f = 0; f < N; f++) in_data[f*DW +: DW] = dat[f];
        #1;
        exp_rdy = '0;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (g < 0 && v[idx] && m_fc[idx] < CAP && m_cnt < D) begin
                g = idx;
                exp_rdy[idx] = 1'b1;
            end
        end
        for (int f = 0; f < N; f++) exp_full[f] = (m_fc[f] == CAP);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_cnt != 0));
        chk("occ", 64'(occ), 64'(m_cnt));
        chk("flow_full", 64'(flow_full), 64'(exp_full));
        if (m_cnt != 0 && dq) begin
            head = sb.pop_front();
            chk("out_data", 64'(out_data), 64'(head[DW-1:0]));
            chk("out_flow", 64'(out_flow), 64'(head[FW+DW-1:DW]));
            m_fc[head[FW+DW-1:DW]]--;
            m_cnt--;
        end
        last_g = g;
        if (g >= 0) begin
            sb.push_back({FW'(g), dat[g]});
            m_fc[g]++;
            m_cnt++;
            m_rr = (g + 1) % N;
        end
        @(negedge clk);
        seq++;
        for (int f = 0; f < N; f++) dat[f] = 32'hC000_0000 | (32'(f) << 20) | 32'(seq);
    endtask

    task automatic drain();
        for (int i = 0; i < D + 2; i++) step('0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = '1;
        in_data = '0;
        out_deque_en = 1'b0;
        for (int f = 0; f < N; f++) dat[f] = 32'hC000_0000 | (32'(f) << 20);
        model_reset();
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_occ", 64'(occ), 64'h0);
        chk("rst_flow_full", 64'(flow_full), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // All flows requesting, no consumer: strict 0,1,2,3 rotation until full.
        for (int i = 0; i < 18; i++) begin
            step(4'b1111, 1'b0);
            if (i < 16) chk("rr_order", 64'(last_g), 64'(i % N));
        end
        chk("fill_occ16", 64'(occ), 64'd16);
        chk("fill_no_grant", 64'(in_ready), 64'h0);
        drain();

        // Single flow runs into its cap; another flow still gets in at once.
        for (int i = 0; i < 10; i++) step(4'b0100, 1'b0);
        chk("cap_occ8", 64'(occ), 64'd8);
        chk("cap_full2", 64'(flow_full), 64'b0100);
        step(4'b0101, 1'b0);
        chk("cap_other_grant", 64'(last_g), 64'd0);
        drain();

        // Push-to-head latency and pop.
        dat[1] = 32'hA5A5_0001;
        step(4'b0010, 1'b0);
        chk("lat_valid", 64'(out_valid), 64'h1);
        chk("lat_data", 64'(out_data), 64'hA5A5_0001);
        step(4'b0000, 1'b1);
        chk("lat_occ0", 64'(occ), 64'h0);
        step(4'b0000, 1'b1);

        // Steady state with occupancy 5: flow 3 pushes while its own entry pops; pointers wrap.
        for (int i = 0; i < 5; i++) step(4'b1000, 1'b0);
        for (int i = 0; i < 40; i++) step(4'b1000, 1'b1);
        chk("steady_occ5", 64'(occ), 64'd5);
        drain();

        // Full buffer: a pop does not free room in the same cycle.
        for (int i = 0; i < 16; i++) step(4'b1111, 1'b0);
        chk("full_occ16", 64'(occ), 64'd16);
        step(4'b1111, 1'b1);
        chk("full_pop_no_grant", 64'(last_g), 64'hFFFF_FFFF_FFFF_FFFF);
        step(4'b1111, 1'b0);
        chk("full_refill", 64'(occ), 64'd16);
        drain();

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 9; i++) step(4'b1111, 1'b0);
        chk("pre_rst_occ9", 64'(occ), 64'd9);
        in_valid = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'h0);
        chk("arst_occ", 64'(occ), 64'h0);
        chk("arst_flow_full", 64'(flow_full), 64'h0);
        chk("arst_in_ready", 64'(in_ready), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(4'b0110, 1'b0);
        chk("post_rst_grant", 64'(last_g), 64'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
